// File: rtl/data_ram_io_pkg.sv
// data_ram_io shared definitions.
// IO register offsets and the 7-segment hex decoder.
package data_ram_io_pkg;

  localparam logic [7:0] IO_BTN_LVL = 8'h20;
  localparam logic [7:0] IO_BTN_EVT = 8'h24;
  localparam logic [7:0] IO_SW      = 8'h28;
  localparam logic [7:0] IO_DISP    = 8'h30;
  localparam logic [7:0] IO_BLANK   = 8'h34;

  // Active-low segments, bit 7 = dp (kept off).
  function automatic logic [7:0] seg_lut(
    input logic [3:0] h
  );
    seg_lut = 8'hFF;
    case (h)
      4'h0: seg_lut = 8'hC0;
      4'h1: seg_lut = 8'hF9;
      4'h2: seg_lut = 8'hA4;
      4'h3: seg_lut = 8'hB0;
      4'h4: seg_lut = 8'h99;
      4'h5: seg_lut = 8'h92;
      4'h6: seg_lut = 8'h82;
      4'h7: seg_lut = 8'hF8;
      4'h8: seg_lut = 8'h80;
      4'h9: seg_lut = 8'h90;
      4'hA: seg_lut = 8'h88;
      4'hB: seg_lut = 8'h83;
      4'hC: seg_lut = 8'hC6;
      4'hD: seg_lut = 8'hA1;
      4'hE: seg_lut = 8'h86;
      4'hF: seg_lut = 8'h8E;
      default: seg_lut = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_io_if.sv
// MEM-stage bus into the data RAM / IO block.
// master = MEM stage, slave = data_ram_io.
interface data_ram_io_if;

  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output ce, we, addr, sel, data_i,
    input  data_o
  );

  modport slave (
    input  ce, we, addr, sel, data_i,
    output data_o
  );

endinterface

// File: rtl/data_ram_io_btn_debounce.sv
// One push-button: 2-flop synchroniser plus a
// stability counter that toggles the accepted level.
module btn_debounce #(
  parameter int DB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_lvl,
  output logic o_rise
);

  localparam int CW = $clog2(DB_CYCLES);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;
  logic          w_hit;

  assign w_hit = (r_s2 != r_lvl) &&
                 (r_cnt == CW'(DB_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_lvl <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_lvl) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_cnt <= '0;
        r_lvl <= ~r_lvl;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_lvl  = r_lvl;
  assign o_rise = w_hit & ~r_lvl;

endmodule

// File: rtl/data_ram_io.sv
// Data RAM with an IO window at word indices 8..15:
// buttons, switches and a scanned 7-segment display.
module data_ram_io
  import data_ram_io_pkg::*;
#(
  parameter int MEM_AW    = 6,
  parameter int NUM_BTN   = 3,
  parameter int SW_W      = 16,
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 2000,
  parameter int DB_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  data_ram_io_if.slave       bus,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic [SW_W-1:0]    sw_i,
  output logic [DIGITS-1:0]  an,
  output logic [7:0]         seg
);

  localparam int DW  = 4 * DIGITS;
  localparam int DVW = $clog2(SCAN_DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [MEM_AW-1:0]  w_idx;
  logic [2:0]         w_reg;
  logic               w_io;
  logic               w_wr;
  logic               w_rd;
  logic [31:0]        w_mask;
  logic               w_wr_ram;
  logic               w_wr_evt;
  logic               w_wr_disp;
  logic               w_wr_blank;
  logic [31:0]        w_io_rd;
  logic [NUM_BTN-1:0] w_lvl;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_clr;
  logic               w_tc;
  logic [3:0]         w_nib;
  logic [DIGITS-1:0]  w_an_nx;
  logic               w_unused;

  logic [31:0]        r_mem [2**MEM_AW];
  logic [NUM_BTN-1:0] r_evt;
  logic [SW_W-1:0]    r_sw1;
  logic [SW_W-1:0]    r_sw2;
  logic [DW-1:0]      r_disp;
  logic [DIGITS-1:0]  r_blank;
  logic [DVW-1:0]     r_div;
  logic [IW-1:0]      r_dig;
  logic [DIGITS-1:0]  r_an;
  logic [7:0]         r_seg;

  assign w_idx    = bus.addr[MEM_AW+1:2];
  assign w_reg    = w_idx[2:0];
  assign w_io     = (w_idx[MEM_AW-1:3] == (MEM_AW-3)'(1));
  assign w_wr     = bus.ce & bus.we;
  assign w_rd     = bus.ce & ~bus.we;
  assign w_unused = ^{bus.addr[31:MEM_AW+2], bus.addr[1:0]};

  assign w_mask = {{8{bus.sel[3]}}, {8{bus.sel[2]}},
                   {8{bus.sel[1]}}, {8{bus.sel[0]}}};

  assign w_wr_ram   = w_wr & ~w_io;
  assign w_wr_evt   = w_wr & w_io &
                      (w_reg == IO_BTN_EVT[4:2]);
  assign w_wr_disp  = w_wr & w_io &
                      (w_reg == IO_DISP[4:2]);
  assign w_wr_blank = w_wr & w_io &
                      (w_reg == IO_BLANK[4:2]);

  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.sel[k])
          r_mem[w_idx][8*k +: 8] <= bus.data_i[8*k +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (btn_i[g]),
      .o_lvl  (w_lvl[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_clr = w_wr_evt ?
    (bus.data_i[NUM_BTN-1:0] & w_mask[NUM_BTN-1:0]) : '0;

  // A rise in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt   <= '0;
      r_sw1   <= '0;
      r_sw2   <= '0;
      r_disp  <= '0;
      r_blank <= '0;
    end else begin
      r_evt <= (r_evt & ~w_clr) | w_rise;
      r_sw1 <= sw_i;
      r_sw2 <= r_sw1;
      if (w_wr_disp)
        r_disp <= (r_disp & ~w_mask[DW-1:0]) |
                  (bus.data_i[DW-1:0] & w_mask[DW-1:0]);
      if (w_wr_blank)
        r_blank <= (r_blank & ~w_mask[DIGITS-1:0]) |
                   (bus.data_i[DIGITS-1:0] &
                    w_mask[DIGITS-1:0]);
    end
  end

  assign w_tc    = (r_div == DVW'(SCAN_DIV - 1));
  assign w_nib   = r_disp[4*r_dig +: 4];
  assign w_an_nx = r_blank[r_dig] ? '1 :
                   ~(DIGITS'(1) << r_dig);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_dig <= '0;
      r_an  <= '1;
      r_seg <= 8'hFF;
    end else if (w_tc) begin
      r_div <= '0;
      r_dig <= (r_dig == IW'(DIGITS - 1)) ?
               '0 : r_dig + IW'(1);
      r_an  <= w_an_nx;
      r_seg <= seg_lut(w_nib);
    end else begin
      r_div <= r_div + DVW'(1);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

  always_comb begin
    w_io_rd = '0;
    case (w_reg)
      IO_BTN_LVL[4:2]: w_io_rd[NUM_BTN-1:0] = w_lvl;
      IO_BTN_EVT[4:2]: w_io_rd[NUM_BTN-1:0] = r_evt;
      IO_SW[4:2]:      w_io_rd[SW_W-1:0]    = r_sw2;
      IO_DISP[4:2]:    w_io_rd[DW-1:0]      = r_disp;
      IO_BLANK[4:2]:   w_io_rd[DIGITS-1:0]  = r_blank;
      default:         w_io_rd = '0;
    endcase
  end

  assign bus.data_o = !w_rd ? '0 :
                      w_io  ? w_io_rd : r_mem[w_idx];

endmodule
